// File: rtl/ram_wrap_pkg.sv
// rtl/ram_wrap_pkg.sv - shared address split, arbitration and counter width for the banked RAM wrapper
package ram_wrap_pkg;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic rd_ready;
        logic wr_ready;
    } grant_t;

    // Low address bits select the bank so consecutive words land in different banks.
    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_bit);
        return addr & ((32'd1 << bank_bit) - 32'd1);
    endfunction

    function automatic logic [31:0] row_of(input logic [31:0] addr, input int bank_bit);
        return addr >> bank_bit;
    endfunction

    function automatic grant_t arbitrate(input logic conflict, input logic prio_rd);
        grant_t g;
        g.rd_ready = ~conflict | prio_rd;
        g.wr_ready = ~conflict | ~prio_rd;
        return g;
    endfunction

endpackage

// File: rtl/ram_bank_sp.sv
// rtl/ram_bank_sp.sv - behavioural single-port bank with registered read output
module ram_bank_sp #(
    parameter int ROW_BIT = 6,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [ROW_BIT-1:0] addr,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout
);

    logic [WIDTH-1:0] mem [2**ROW_BIT];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
            end else begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_banked_sp_wrap.sv
// rtl/ram_banked_sp_wrap.sv - interleaved multi-bank RAM wrapper; RAM_CONFLICT_CNT_EN adds conflict_cnt
module ram_banked_sp_wrap
    import ram_wrap_pkg::*;
#(
    parameter int DEPTH_BIT = 8,
    parameter int WIDTH     = 32,
    parameter int BANK_BIT  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req,
    input  logic [DEPTH_BIT-1:0] rd_addr,
    output logic                 rd_ready,
    output logic                 rd_valid,
    output logic [WIDTH-1:0]     rd_data,
    input  logic                 wr_req,
    input  logic [DEPTH_BIT-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    output logic                 wr_ready
`ifdef RAM_CONFLICT_CNT_EN
    ,
    output logic [CNT_W-1:0]     conflict_cnt
`endif
);

    localparam int NUM_BANKS = 1 << BANK_BIT;
    localparam int ROW_BIT   = DEPTH_BIT - BANK_BIT;
    localparam int BANK_W    = (BANK_BIT > 0) ? BANK_BIT : 1;

    logic [BANK_W-1:0]  rd_bank;
    logic [BANK_W-1:0]  wr_bank;
    logic [ROW_BIT-1:0] rd_row;
    logic [ROW_BIT-1:0] wr_row;
    logic               conflict;
    logic               prio_rd;
    logic               rd_acc;
    logic               wr_acc;
    grant_t             grant;

    logic [WIDTH-1:0]   bank_dout [NUM_BANKS];
    logic [BANK_W-1:0]  rd_bank_q;
    logic               rd_valid_q;
    logic [WIDTH-1:0]   hold_q;
    logic [WIDTH-1:0]   rd_word;

    assign rd_bank = BANK_W'(bank_of(32'(rd_addr), BANK_BIT));
    assign wr_bank = BANK_W'(bank_of(32'(wr_addr), BANK_BIT));
    assign rd_row  = ROW_BIT'(row_of(32'(rd_addr), BANK_BIT));
    assign wr_row  = ROW_BIT'(row_of(32'(wr_addr), BANK_BIT));

    assign conflict = rd_req & wr_req & (rd_bank == wr_bank);
    assign grant    = arbitrate(conflict, prio_rd);
    assign rd_ready = grant.rd_ready;
    assign wr_ready = grant.wr_ready;
    assign rd_acc   = rd_req & grant.rd_ready;
    assign wr_acc   = wr_req & grant.wr_ready;

    // Accepted read and write never target the same bank, so each bank sees at most one access.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic sel_rd;
        logic sel_wr;

        assign sel_rd = rd_acc & (rd_bank == BANK_W'(b));
        assign sel_wr = wr_acc & (wr_bank == BANK_W'(b));

        ram_bank_sp #(
            .ROW_BIT(ROW_BIT),
            .WIDTH  (WIDTH)
        ) u_bank (
            .clk (clk),
            .en  (sel_rd | sel_wr),
            .we  (sel_wr),
            .addr(sel_wr ? wr_row : rd_row),
            .din (wr_data),
            .dout(bank_dout[b])
        );
    end

    always_comb begin
        rd_word = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (rd_bank_q == BANK_W'(b)) begin
                rd_word = bank_dout[b];
            end
        end
    end

    // Bank outputs drift on later accesses, so the returned word is captured for holding.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_bank_q  <= '0;
            prio_rd    <= 1'b0;
            hold_q     <= '0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_bank_q <= rd_bank;
            end
            if (rd_acc) begin
                prio_rd <= 1'b0;
            end else if (conflict) begin
                prio_rd <= 1'b1;
            end
            if (rd_valid_q) begin
                hold_q <= rd_word;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? rd_word : hold_q;

`ifdef RAM_CONFLICT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_banked_sp_wrap.sv
// tb/tb_ram_banked_sp_wrap.sv - self-checking bench: directed plan plus random traffic against a reference model
module tb_ram_banked_sp_wrap;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        rd_req = 1'b0, wr_req = 1'b0;
    logic [7:0]  rd_addr = '0, wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_ready, wr_ready, rd_valid;
    logic [31:0] rd_data;
    logic [15:0] cnt;

    logic        z_rst = 1'b1;
    logic        z_rd_req = 1'b0, z_wr_req = 1'b0;
    logic [3:0]  z_rd_addr = '0, z_wr_addr = '0;
    logic [31:0] z_wr_data = '0;
    logic        z_rd_ready, z_wr_ready, z_rd_valid;
    logic [31:0] z_rd_data;
    logic [15:0] z_cnt;

    ram_banked_sp_wrap #(.DEPTH_BIT(8), .WIDTH(32), .BANK_BIT(2)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
`ifdef RAM_CONFLICT_CNT_EN
        , .conflict_cnt(cnt)
`endif
    );

    ram_banked_sp_wrap #(.DEPTH_BIT(4), .WIDTH(32), .BANK_BIT(0)) dut_one (
        .clk(clk), .rst(z_rst),
        .rd_req(z_rd_req), .rd_addr(z_rd_addr), .rd_ready(z_rd_ready),
        .rd_valid(z_rd_valid), .rd_data(z_rd_data),
        .wr_req(z_wr_req), .wr_addr(z_wr_addr), .wr_data(z_wr_data), .wr_ready(z_wr_ready)
`ifdef RAM_CONFLICT_CNT_EN
        , .conflict_cnt(z_cnt)
`endif
    );

`ifndef RAM_CONFLICT_CNT_EN
    assign cnt   = '0;
    assign z_cnt = '0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words by address, a "read was turned away" flag, returned word, conflict tally.
    logic [31:0] m_mem [256];
    bit          m_prio = 0;
    bit          m_valid = 0;
    logic [31:0] m_data = '0;
    int          m_cnt = 0;
    bit          chk_en = 0;

    function automatic bit m_conflict();
        return rd_req && wr_req && ((rd_addr % 4) == (wr_addr % 4));
    endfunction

    always @(posedge clk) begin : model
        bit conf, racc, wacc;
        conf = m_conflict();
        racc = rd_req && (!conf || m_prio);
        wacc = wr_req && (!conf || !m_prio);
        if (wacc) m_mem[wr_addr] = wr_data;
        if (rst) begin
            m_valid = 0;
            m_data  = '0;
            m_prio  = 0;
            m_cnt   = 0;
        end else begin
            m_valid = racc;
            if (racc) m_data = m_mem[rd_addr];
            if (racc) m_prio = 0;
            else if (conf) m_prio = 1;
            if (conf && m_cnt < 65535) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_ready", rd_ready, !m_conflict() || m_prio);
            chk("wr_ready", wr_ready, !m_conflict() || !m_prio);
            chk("rd_valid", rd_valid, m_valid);
            chk("rd_data", rd_data, m_data);
`ifdef RAM_CONFLICT_CNT_EN
            chk("conflict_cnt", cnt, m_cnt);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] e2, e8, wd, c0;
        bit rt, wt;

        step();
        chk_en = 1;
        @(negedge clk);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        step();
        rst = 0;

        for (int a = 0; a < 256; a++) begin
            wr_req = 1; wr_addr = 8'(a); wr_data = $urandom;
            step();
        end
        wr_req = 0;

        // basic write then read, data held for 5 idle cycles
        wr_req = 1; wr_addr = 8'h05; wr_data = 32'hDEADBEEF;
        step();
        wr_req = 0; rd_req = 1; rd_addr = 8'h05;
        @(negedge clk);
        chk("t1_rd_ready", rd_ready, 1);
        step();
        rd_req = 0;
        chk("t1_rd_valid", rd_valid, 1);
        chk("t1_rd_data", rd_data, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_hold_data", rd_data, 32'hDEADBEEF);
            chk("t1_hold_valid", rd_valid, 0);
        end

        // parallel access to different banks
        e2 = m_mem[2]; wd = $urandom;
        wr_req = 1; wr_addr = 8'h01; wr_data = wd;
        rd_req = 1; rd_addr = 8'h02;
        @(negedge clk);
        chk("t2_rd_ready", rd_ready, 1);
        chk("t2_wr_ready", wr_ready, 1);
        step();
        wr_req = 0; rd_req = 0;
        chk("t2_rd_valid", rd_valid, 1);
        chk("t2_rd_data", rd_data, e2);
        rd_req = 1; rd_addr = 8'h01;
        step();
        rd_req = 0;
        chk("t2_wr_back", rd_data, wd);

        // single conflict
        step();
        c0 = 32'(cnt); e8 = m_mem[8];
        wr_req = 1; wr_addr = 8'h04; wr_data = $urandom;
        rd_req = 1; rd_addr = 8'h08;
        @(negedge clk);
        chk("t3_c0_wr_ready", wr_ready, 1);
        chk("t3_c0_rd_ready", rd_ready, 0);
        step();
        wr_req = 0;
        @(negedge clk);
        chk("t3_c1_rd_ready", rd_ready, 1);
        step();
        rd_req = 0;
        chk("t3_rd_data", rd_data, e8);
`ifdef RAM_CONFLICT_CNT_EN
        chk("t3_cnt_delta", 32'(cnt) - c0, 1);
`endif

        // continuous same-bank contention: grants alternate W, R, W, R ...
        step();
        c0 = 32'(cnt);
        wr_req = 1; wr_addr = 8'h20; wr_data = $urandom;
        rd_req = 1; rd_addr = 8'h24;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_wr_grant", wr_ready, (i % 2) == 0);
            chk("t4_rd_grant", rd_ready, (i % 2) == 1);
            step();
            wr_data = $urandom;
        end
        wr_req = 0; rd_req = 0;
`ifdef RAM_CONFLICT_CNT_EN
        chk("t4_cnt_delta", 32'(cnt) - c0, 8);
`endif

        // read-after-write to the same address
        step();
        wr_req = 1; wr_addr = 8'h10; wr_data = 32'h1;
        rd_req = 1; rd_addr = 8'h10;
        @(negedge clk);
        chk("t5_wr_first", wr_ready, 1);
        chk("t5_rd_wait", rd_ready, 0);
        step();
        wr_req = 0;
        @(negedge clk);
        chk("t5_rd_ready", rd_ready, 1);
        step();
        rd_req = 0;
        chk("t5_rd_valid", rd_valid, 1);
        chk("t5_rd_data", rd_data, 32'h1);

        // random traffic obeying the hold-until-ready rule
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rt = rd_req && rd_ready;
            wt = wr_req && wr_ready;
            step();
            if (!wr_req || wt) begin
                wr_req = ($urandom % 4) != 0;
                wr_addr = 8'($urandom);
                wr_data = $urandom;
            end
            if (!rd_req || rt) begin
                rd_req = ($urandom % 4) != 0;
                rd_addr = ($urandom % 3 == 0) ? wr_addr : 8'($urandom);
            end
        end
        step();
        rd_req = 0; wr_req = 0;

        // reset on a read-acceptance edge; a write on the same edge still commits
        step();
        wr_req = 1; wr_addr = 8'h05; wr_data = 32'hCAFEF00D;
        step();
        wr_req = 0; rd_req = 1; rd_addr = 8'h05;
        step();
        rd_req = 0;
        chk("t6_pre_data", rd_data, 32'hCAFEF00D);
        rd_req = 1; rd_addr = 8'h05;
        wr_req = 1; wr_addr = 8'h06; wr_data = 32'h12345678;
        rst = 1;
        step();
        rst = 0; rd_req = 0; wr_req = 0;
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_rd_data", rd_data, 0);
`ifdef RAM_CONFLICT_CNT_EN
        chk("t6_cnt", cnt, 0);
`endif
        wr_req = 1; wr_addr = 8'h30; wr_data = $urandom;
        rd_req = 1; rd_addr = 8'h34;
        @(negedge clk);
        chk("t6_prio_wr", wr_ready, 1);
        chk("t6_prio_rd", rd_ready, 0);
        step();
        wr_req = 0;
        step();
        rd_req = 0; rd_addr = 8'h06;
        rd_req = 1;
        step();
        rd_req = 0;
        chk("t6_wr_on_reset", rd_data, 32'h12345678);

        // single-bank instance
        step();
        z_rst = 0;
        z_wr_req = 1; z_wr_addr = 4'd3; z_wr_data = 32'hA5A5A5A5;
        step();
        z_wr_req = 0; z_rd_req = 1; z_rd_addr = 4'd3;
        step();
        z_rd_req = 0;
        chk("z_rd_valid", z_rd_valid, 1);
        chk("z_rd_data", z_rd_data, 32'hA5A5A5A5);
        step();
        z_wr_req = 1; z_wr_addr = 4'd7; z_wr_data = 32'h77;
        z_rd_req = 1; z_rd_addr = 4'd3;
        @(negedge clk);
        chk("z_conf_wr", z_wr_ready, 1);
        chk("z_conf_rd", z_rd_ready, 0);
        step();
        z_wr_req = 0; z_rst = 1;
        @(negedge clk);
        chk("z_rd_ready", z_rd_ready, 1);
        step();
        z_rst = 0; z_rd_req = 0;
        chk("z_rst_valid", z_rd_valid, 0);
        chk("z_rst_data", z_rd_data, 0);
`ifdef RAM_CONFLICT_CNT_EN
        chk("z_rst_cnt", z_cnt, 0);
`endif
        z_rd_req = 1; z_rd_addr = 4'd7;
        step();
        z_rd_req = 0;
        chk("z_wr_back", z_rd_data, 32'h77);

        step();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_banked_sp_wrap.md
# ram_banked_sp_wrap

Parametrised, multi-bank successor to the single-bank global-buffer SRAM wrappers. It accepts one read request and one write request per cycle over valid/ready handshakes and maps them onto NUM_BANKS single-port banks, with addresses interleaved across banks. Same-bank conflicts are resolved with write priority plus an anti-starvation flag. Read data is held stable between reads. The block sits between the global-buffer controllers and the bank macros.

## Interface
- DEPTH_BIT, 8: total address width. Total depth is 2**DEPTH_BIT words.
- WIDTH, 32: data word width.
- BANK_BIT, 2: log2 of the bank count. NUM_BANKS = 2**BANK_BIT, and BANK_BIT < DEPTH_BIT. BANK_BIT=0 gives a single bank.
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  read request. Must be held with rd_addr stable until rd_ready.
- rd_addr  in  DEPTH_BIT  read address.
- rd_ready  out  1  read accepted this cycle when rd_req=1.
- rd_valid  out  1  one-cycle pulse, the cycle after acceptance.
- rd_data  out  WIDTH  read word. Held until the next accepted read returns.
- wr_req  in  1  write request. Must be held with wr_addr/wr_data stable until wr_ready.
- wr_addr  in  DEPTH_BIT  write address.
- wr_data  in  WIDTH  write word.
- wr_ready  out  1  write accepted this cycle when wr_req=1.
- conflict_cnt  out  16  saturating count of same-bank conflicts. Present only with RAM_CONFLICT_CNT_EN.

## Operation
- Address decoding:
  - bank = addr[BANK_BIT-1:0]
  - row = addr[DEPTH_BIT-1:BANK_BIT]
- Conflict condition: conflict = rd_req & wr_req & (rd bank == wr bank).
- Ready logic is combinational from the inputs and the prio_rd flag:
  - rd_ready = ~conflict | prio_rd
  - wr_ready = ~conflict | ~prio_rd
  - With no conflict, both readies are 1.
- prio_rd flag:
  - Set on a cycle where conflict=1 and the read is stalled.
  - Cleared on a cycle where the read is accepted.
  - Result: a read waits at most one cycle, and conflicts alternate write, read, write, and so on.
- An accepted write commits mem[bank][row] <= wr_data at that clock edge.
- An accepted read samples its bank at that edge. The next cycle drives rd_data with the word and pulses rd_valid=1.
- Reads and writes to different banks proceed in the same cycle.
- Read/write to the same address cannot be accepted together, because it is by definition a conflict. A read granted after a write to the same address returns the new data.
- Memory contents are not reset and power up as X.

## Timing
- Reset values: rd_valid=0, rd_data=0, prio_rd=0, conflict_cnt=0.
- Read latency is 1 cycle: accepted at edge N, rd_valid/rd_data are valid in cycle N+1.
- Write latency is 1 cycle: data is visible to a read accepted at edge N+1 or later.
- Throughput is one read plus one write per cycle when the banks differ.
- Worst-case stall is 1 cycle for either port under continuous same-bank conflicts.
- rd_data changes only in the cycle rd_valid=1. Otherwise it holds, including while rd_req is stalled.
- Reset asserted mid-operation:
  - A read accepted on the reset edge produces no rd_valid.
  - A write accepted on the reset edge still commits.
  - All outputs return to their reset values the cycle after.

## Configuration
- RAM_CONFLICT_CNT_EN defined:
  - conflict_cnt exists.
  - It increments by 1 on every cycle with conflict=1.
  - It saturates at 16'hFFFF.
  - Reset clears it to 0.
- RAM_CONFLICT_CNT_EN undefined: the port and the counter logic are absent. All other behaviour is identical.

## Structure
- Package ram_wrap_pkg holds:
  - bank_of() and row_of() address-split functions, parameterised by BANK_BIT.
  - localparam CNT_W = 16.
  - The ready-arbitration function taking (conflict, prio_rd).
- Sub-module ram_bank_sp: one behavioural single-port bank of depth 2**(DEPTH_BIT-BANK_BIT).
  - Ports: en, we, addr, din, dout. Output is registered; write and read never occur together.
  - Instantiated NUM_BANKS times in a generate loop.
  - Top level holds the output mux, which registers the read bank index, plus the prio_rd flag, the hold register and the counter.

## Test plan
- Basic write then read: write addr 8'h05 = 32'hDEADBEEF, then read addr 8'h05 → rd_valid one cycle after acceptance, rd_data=32'hDEADBEEF, held for 5 idle cycles.
- Parallel, different banks: same cycle write 8'h01, read 8'h02 (BANK_BIT=2) → both readies 1; rd_data returns the prior contents of 8'h02.
- Single conflict: write 8'h04, read 8'h08 held together → cycle 0: wr_ready=1, rd_ready=0; cycle 1: rd_ready=1; conflict_cnt=1.
- Continuous same-bank contention for 8 cycles → grants alternate W, R, W, R, …; no port is stalled more than 1 cycle; conflict_cnt=8.
- Read-after-write, same address: write 8'h10=32'h1 and read 8'h10 together → write first, read next cycle returns 32'h1.
- Reset mid-read: assert rst on the read acceptance edge → rd_valid stays 0, rd_data=0, prio_rd=0, conflict_cnt=0. Run with BANK_BIT=0 as well.
